pim_conv_seq: RTL

Initiator-side sequencer for the PIM crossbar compute path. It accepts one input feature vector per transaction over a valid/ready handshake and holds it stable on the crossbar input. It then sweeps every crossbar column address and drives compute enable, capturing each ADC result after the fixed crossbar latency. The captured results are streamed out in column order through a credit-protected result FIFO, so downstream backpressure never loses an in-flight result.

---
 rtl/pim_pkg.sv | 24 ++
 rtl/pim_res_fifo.sv | 50 +++++
 rtl/pim_conv_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pim_pkg.sv
// Shared types for the PIM crossbar sequencer: FSM state encoding and the result FIFO entry.
package pim_pkg;

  localparam int PIM_ADC_P = 8;
  localparam int PIM_DEPTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } pim_state_e;

  typedef struct packed {
    logic [PIM_ADC_P-1:0] data;
    logic [PIM_DEPTH-1:0] addr;
    logic                 last;
  } res_entry_t;

  // ADC codes are two's complement when rectification is enabled.
  function automatic logic [PIM_ADC_P-1:0] relu_clamp(input logic [PIM_ADC_P-1:0] v);
    return v[PIM_ADC_P-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/pim_res_fifo.sv
// Result FIFO for the crossbar sequencer: registered storage, head presented directly,
// occupancy exported so the issuer can reserve space before launching a column.
module pim_res_fifo
  import pim_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  res_entry_t                   push_data,
  input  logic                         pop,
  output res_entry_t                   q,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  res_entry_t     mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign q     = mem[rd_ptr];
  assign valid = (cnt != '0);
  assign count = cnt;

endmodule

// File: rtl/pim_conv_seq.sv
// PIM crossbar sweep sequencer: latches a feature vector, issues every column under FIFO credit,
// captures ADC results after LAT cycles. Build option PIM_RELU_EN rectifies signed ADC codes.
//
// state | meaning
// IDLE  | ready for a new feature vector
// ISSUE | sweeping column addresses while credit allows
// DRAIN | sweep issued, waiting for in-flight results to land in the FIFO
module pim_conv_seq
  import pim_pkg::*;
#(
  parameter int INPUT_SIZE = 192,
  parameter int DEPTH      = PIM_DEPTH,
  parameter int ADC_P      = PIM_ADC_P,
  parameter int LAT        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INPUT_SIZE-1:0] in_feature,
  output logic                  pim_en,
  output logic [DEPTH-1:0]      pim_addr,
  output logic [INPUT_SIZE-1:0] pim_feature,
  input  logic [ADC_P-1:0]      pim_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADC_P-1:0]      out_data,
  output logic [DEPTH-1:0]      out_addr,
  output logic                  out_last,
  output logic                  busy
);

  localparam int COLS = 2 ** DEPTH;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [DEPTH-1:0] LAST_COL = DEPTH'(COLS - 1);

  logic [1:0]            state;
  logic [DEPTH-1:0]      col;
  logic [INPUT_SIZE-1:0] feat_q;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         inflight_nx;
  logic [CW-1:0]         fifo_count;
  logic [LAT-1:0]        sr_v;
  logic [DEPTH-1:0]      sr_a [LAT];
  logic                  issue;
  logic                  cap_v;
  logic [DEPTH-1:0]      cap_a;
  logic [ADC_P-1:0]      cap_d;
  logic                  fifo_valid;
  logic                  pop;
  res_entry_t            push_e;
  res_entry_t            head;

  // Reserve a FIFO slot for every in-flight column so a stalled consumer never drops a result.
  assign issue = (state == ISSUE) && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
  assign cap_v = sr_v[LAT-1];
  assign cap_a = sr_a[LAT-1];

`ifdef PIM_RELU_EN
  assign cap_d = relu_clamp(pim_result);
`else
  assign cap_d = pim_result;
`endif

  assign push_e = '{data: cap_d, addr: cap_a, last: (cap_a == LAST_COL)};

  always_comb begin
    inflight_nx = inflight;
    if (issue && !cap_v)      inflight_nx = inflight + CW'(1);
    else if (!issue && cap_v) inflight_nx = inflight - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_v <= '0;
      for (int i = 0; i < LAT; i++) sr_a[i] <= '0;
      inflight <= '0;
    end else begin
      sr_v[0] <= issue;
      sr_a[0] <= col;
      for (int i = 1; i < LAT; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_a[i] <= sr_a[i-1];
      end
      inflight <= inflight_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      col    <= '0;
      feat_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          feat_q <= in_feature;
          col    <= '0;
          state  <= ISSUE;
        end
        ISSUE: if (issue) begin
          col <= col + DEPTH'(1);
          if (col == LAST_COL) state <= DRAIN;
        end
        DRAIN: if (inflight_nx == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  pim_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_v),
    .push_data (push_e),
    .pop       (pop),
    .q         (head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign pop         = fifo_valid && out_ready;
  assign in_ready    = (state == IDLE);
  assign pim_en      = issue;
  assign pim_addr    = col;
  assign pim_feature = feat_q;
  assign out_valid   = fifo_valid;
  assign out_data    = head.data;
  assign out_addr    = head.addr;
  assign out_last    = head.last;
  assign busy        = (state != IDLE) || fifo_valid;

endmodule
